// File: rtl/fft_frame_ctrl.sv
// Sequencer between the FX2 USB front end and the FFT core: loads twiddle weights,
// admits frames through a one-frame holding register, and bounds frames inside the core.
module fft_frame_ctrl #(
  parameter int NPOINT       = 3,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wt_valid,
  input  logic [15:0]                   wt_real,
  input  logic [15:0]                   wt_imag,
  output logic                          core_weight_valid,
  output logic [2*NPOINT-1:0]           core_weight_addr,
  output logic [15:0]                   core_weight_real,
  output logic [15:0]                   core_weight_imag,
  output logic                          weights_ready,
  input  logic                          cfg_reload,
  input  logic                          up_din_valid,
  output logic                          up_din_busy,
  input  logic [16*(2**NPOINT)-1:0]     up_din_real,
  input  logic [16*(2**NPOINT)-1:0]     up_din_imag,
  output logic                          core_din_valid,
  input  logic                          core_din_busy,
  output logic [16*(2**NPOINT)-1:0]     core_din_real,
  output logic [16*(2**NPOINT)-1:0]     core_din_imag,
  input  logic                          core_dout_valid,
  output logic                          core_dout_busy,
  output logic                          up_dout_valid,
  input  logic                          up_dout_busy,
  output logic [2:0]                    inflight,
  output logic [15:0]                   frame_cnt,
  output logic                          err_unexp
);

  localparam int FW   = 16 * (2 ** NPOINT);
  localparam int WNUM = NPOINT * (2 ** (NPOINT - 1));
  localparam int WA   = 2 * NPOINT;

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [WA-1:0]   wcnt_q, wcnt_d;
  logic            wvalid_q, wvalid_d;
  logic [WA-1:0]   waddr_q, waddr_d;
  logic [15:0]     wreal_q, wreal_d;
  logic [15:0]     wimag_q, wimag_d;
  logic            ready_q, ready_d;
  logic            din_valid_q, din_valid_d;
  logic [FW-1:0]   din_real_q, din_real_d;
  logic [FW-1:0]   din_imag_q, din_imag_d;
  logic [2:0]      inflight_q, inflight_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            err_q, err_d;

  logic in_xfer;
  logic core_xfer;
  logic out_xfer;

  // Result data bypasses this block; only the handshake is observed.
  assign up_dout_valid  = core_dout_valid;
  assign core_dout_busy = up_dout_busy;

  assign up_din_busy = (state_q != RUN) | din_valid_q | (inflight_q == 3'(MAX_INFLIGHT));
  assign in_xfer     = up_din_valid & ~up_din_busy;
  assign core_xfer   = din_valid_q & ~core_din_busy;
  assign out_xfer    = core_dout_valid & ~up_dout_busy;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    wvalid_d    = 1'b0;
    waddr_d     = waddr_q;
    wreal_d     = wreal_q;
    wimag_d     = wimag_q;
    ready_d     = ready_q;
    din_valid_d = din_valid_q;
    din_real_d  = din_real_q;
    din_imag_d  = din_imag_q;
    inflight_d  = inflight_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    case (state_q)
      LOAD: begin
        if (wt_valid) begin
          wvalid_d = 1'b1;
          waddr_d  = wcnt_q;
          wreal_d  = wt_real;
          wimag_d  = wt_imag;
          if (wcnt_q == WA'(WNUM - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (cfg_reload) state_d = DRAIN;
      end
      DRAIN: begin
        // Reload only once nothing is held or still inside the core.
        if ((inflight_q == 3'd0) && !din_valid_q) begin
          state_d = LOAD;
          ready_d = 1'b0;
          wcnt_d  = '0;
        end
      end
      default: state_d = LOAD;
    endcase

    if (in_xfer) begin
      din_valid_d = 1'b1;
      din_real_d  = up_din_real;
      din_imag_d  = up_din_imag;
    end
    if (core_xfer) din_valid_d = 1'b0;

    if (out_xfer) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (inflight_q == 3'd0) err_d = 1'b1;
    end

    // An unexpected result never drives the count below zero.
    case ({core_xfer, out_xfer})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   if (inflight_q != 3'd0) inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      wcnt_q      <= '0;
      wvalid_q    <= 1'b0;
      waddr_q     <= '0;
      wreal_q     <= '0;
      wimag_q     <= '0;
      ready_q     <= 1'b0;
      din_valid_q <= 1'b0;
      din_real_q  <= '0;
      din_imag_q  <= '0;
      inflight_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      wvalid_q    <= wvalid_d;
      waddr_q     <= waddr_d;
      wreal_q     <= wreal_d;
      wimag_q     <= wimag_d;
      ready_q     <= ready_d;
      din_valid_q <= din_valid_d;
      din_real_q  <= din_real_d;
      din_imag_q  <= din_imag_d;
      inflight_q  <= inflight_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign core_weight_valid = wvalid_q;
  assign core_weight_addr  = waddr_q;
  assign core_weight_real  = wreal_q;
  assign core_weight_imag  = wimag_q;
  assign weights_ready     = ready_q;
  assign core_din_valid    = din_valid_q;
  assign core_din_real     = din_real_q;
  assign core_din_imag     = din_imag_q;
  assign inflight          = inflight_q;
  assign frame_cnt         = frame_cnt_q;
  assign err_unexp         = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: random handshakes checked against a
// transaction-level model of weight loading, frame admission and in-flight accounting.
module tb_fft_frame_ctrl;

  localparam int NPOINT       = 3;
  localparam int MAX_INFLIGHT = 2;
  localparam int FW           = 16 * (2 ** NPOINT);
  localparam int WNUM         = NPOINT * (2 ** (NPOINT - 1));
  localparam int WA           = 2 * NPOINT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wt_valid = 1'b0;
  logic [15:0]   wt_real = '0;
  logic [15:0]   wt_imag = '0;
  logic          core_weight_valid;
  logic [WA-1:0] core_weight_addr;
  logic [15:0]   core_weight_real;
  logic [15:0]   core_weight_imag;
  logic          weights_ready;
  logic          cfg_reload = 1'b0;
  logic          up_din_valid = 1'b0;
  logic          up_din_busy;
  logic [FW-1:0] up_din_real = '0;
  logic [FW-1:0] up_din_imag = '0;
  logic          core_din_valid;
  logic          core_din_busy = 1'b0;
  logic [FW-1:0] core_din_real;
  logic [FW-1:0] core_din_imag;
  logic          core_dout_valid = 1'b0;
  logic          core_dout_busy;
  logic          up_dout_valid;
  logic          up_dout_busy = 1'b0;
  logic [2:0]    inflight;
  logic [15:0]   frame_cnt;
  logic          err_unexp;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.NPOINT(NPOINT), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .rst(rst),
    .wt_valid(wt_valid), .wt_real(wt_real), .wt_imag(wt_imag),
    .core_weight_valid(core_weight_valid), .core_weight_addr(core_weight_addr),
    .core_weight_real(core_weight_real), .core_weight_imag(core_weight_imag),
    .weights_ready(weights_ready), .cfg_reload(cfg_reload),
    .up_din_valid(up_din_valid), .up_din_busy(up_din_busy),
    .up_din_real(up_din_real), .up_din_imag(up_din_imag),
    .core_din_valid(core_din_valid), .core_din_busy(core_din_busy),
    .core_din_real(core_din_real), .core_din_imag(core_din_imag),
    .core_dout_valid(core_dout_valid), .core_dout_busy(core_dout_busy),
    .up_dout_valid(up_dout_valid), .up_dout_busy(up_dout_busy),
    .inflight(inflight), .frame_cnt(frame_cnt), .err_unexp(err_unexp)
  );

  typedef struct {
    logic wvalid;
    logic ready;
    logic din_busy;
    logic din_valid;
    int   inflight;
    int   frames;
    logic err;
  } status_t;

  typedef struct {
    int          addr;
    logic [15:0] re;
    logic [15:0] im;
  } weight_t;

  typedef struct {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
  } frame_t;

  status_t status_q[$];
  weight_t weight_q[$];
  frame_t  frame_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = loading weights, 1 = running, 2 = draining.
  int m_mode;
  int m_wcount;
  int m_inflight;
  int m_frames;
  bit m_ready;
  bit m_hold;
  bit m_err;
  bit m_wstrobe;

  function automatic bit model_busy();
    return (m_mode != 1) || m_hold || (m_inflight == MAX_INFLIGHT);
  endfunction

  task automatic check_output(input string name, input logic [FW-1:0] actual,
                              input logic [FW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wcount = 0; m_inflight = 0; m_frames = 0;
    m_ready = 0; m_hold = 0; m_err = 0; m_wstrobe = 0;
    weight_q.delete();
    frame_q.delete();
  endtask

  task automatic push_status();
    status_t s;
    s.wvalid    = m_wstrobe;
    s.ready     = m_ready;
    s.din_busy  = model_busy();
    s.din_valid = m_hold;
    s.inflight  = m_inflight;
    s.frames    = m_frames;
    s.err       = m_err;
    status_q.push_back(s);
  endtask

  // Applies the rules of one clock edge to the model, using the inputs held across that edge.
  task automatic model_step();
    bit in_x, core_x, out_x;
    weight_t w;
    frame_t  f;
    in_x   = up_din_valid && !model_busy();
    core_x = m_hold && !core_din_busy;
    out_x  = core_dout_valid && !up_dout_busy;
    m_wstrobe = 0;
    case (m_mode)
      0: if (wt_valid) begin
        w.addr = m_wcount; w.re = wt_real; w.im = wt_imag;
        weight_q.push_back(w);
        m_wstrobe = 1;
        if (m_wcount == WNUM - 1) begin
          m_mode = 1; m_ready = 1; m_wcount = 0;
        end else begin
          m_wcount++;
        end
      end
      1: if (cfg_reload) m_mode = 2;
      default: if (m_inflight == 0 && !m_hold) begin
        m_mode = 0; m_ready = 0; m_wcount = 0;
      end
    endcase
    if (in_x) begin
      f.re = up_din_real; f.im = up_din_imag;
      frame_q.push_back(f);
      m_hold = 1;
    end
    if (core_x) m_hold = 0;
    if (out_x) begin
      m_frames = (m_frames + 1) % 65536;
      if (m_inflight == 0) m_err = 1;
    end
    if (core_x && !out_x) m_inflight++;
    else if (out_x && !core_x && m_inflight > 0) m_inflight--;
  endtask

  // Phase 0: first weight load, 1: normal traffic, 2: unsolicited results, 3: quiet.
  task automatic apply_stimulus(input int phase);
    if (phase == 3) begin
      wt_valid = 0; up_din_valid = 0; cfg_reload = 0;
      core_din_busy = 1; core_dout_valid = 0; up_dout_busy = 0;
    end else begin
      wt_valid      = ($urandom_range(99) < ((phase == 0) ? 70 : 30));
      wt_real       = (phase == 0) ? 16'(16'h0100 + m_wcount) : 16'($urandom);
      wt_imag       = 16'($urandom);
      up_din_valid  = ($urandom_range(99) < 50);
      up_din_real   = {$urandom, $urandom, $urandom, $urandom};
      up_din_imag   = {$urandom, $urandom, $urandom, $urandom};
      core_din_busy = ($urandom_range(99) < 40);
      up_dout_busy  = ($urandom_range(99) < 25);
      cfg_reload    = (phase != 0) && ($urandom_range(99) < 3);
      if (phase == 2) core_dout_valid = ($urandom_range(99) < 30);
      else            core_dout_valid = (m_inflight > 0) && ($urandom_range(99) < 40);
    end
  endtask

  task automatic step_cycle(input int phase);
    @(posedge clk);
    #1;
    model_step();
    push_status();
    apply_stimulus(phase);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    wt_valid = 0; up_din_valid = 0; cfg_reload = 0;
    core_din_busy = 0; core_dout_valid = 0; up_dout_busy = 0;
    model_reset();
    push_status();
    @(posedge clk);
    #1;
    rst = 0;
    push_status();
  endtask

  // Monitor: compares whatever the DUT presents against the expectations queued by the driver.
  always @(negedge clk) begin
    status_t s;
    weight_t w;
    frame_t  f;
    if (status_q.size() > 0) begin
      s = status_q.pop_front();
      check_output("core_weight_valid", FW'(core_weight_valid), FW'(s.wvalid));
      check_output("weights_ready", FW'(weights_ready), FW'(s.ready));
      check_output("up_din_busy", FW'(up_din_busy), FW'(s.din_busy));
      check_output("core_din_valid", FW'(core_din_valid), FW'(s.din_valid));
      check_output("inflight", FW'(inflight), FW'(s.inflight));
      check_output("frame_cnt", FW'(frame_cnt), FW'(s.frames));
      check_output("err_unexp", FW'(err_unexp), FW'(s.err));
      check_output("up_dout_valid", FW'(up_dout_valid), FW'(core_dout_valid));
      check_output("core_dout_busy", FW'(core_dout_busy), FW'(up_dout_busy));
    end
    if (core_weight_valid) begin
      if (weight_q.size() == 0) begin
        check_output("weight_strobe_expected", FW'(1), FW'(weight_q.size()));
      end else begin
        w = weight_q.pop_front();
        check_output("core_weight_addr", FW'(core_weight_addr), FW'(w.addr));
        check_output("core_weight_real", FW'(core_weight_real), FW'(w.re));
        check_output("core_weight_imag", FW'(core_weight_imag), FW'(w.im));
      end
    end
    if (core_din_valid && !core_din_busy) begin
      if (frame_q.size() == 0) begin
        check_output("frame_expected", FW'(1), FW'(frame_q.size()));
      end else begin
        f = frame_q.pop_front();
        check_output("core_din_real", core_din_real, f.re);
        check_output("core_din_imag", core_din_imag, f.im);
      end
    end
  end

  initial begin
    int n;
    do_reset();
    apply_stimulus(0);
    n = 0;
    while (!m_ready && n < 200) begin
      step_cycle(0);
      n++;
    end
    check_output("first_load_done", FW'(m_ready), FW'(1));
    repeat (400) step_cycle(1);
    repeat (100) step_cycle(2);
    repeat (60)  step_cycle(1);
    do_reset();
    apply_stimulus(1);
    repeat (300) step_cycle(1);
    repeat (3)   step_cycle(3);
    @(negedge clk);
    #1;
    check_output("weight_queue_drained", FW'(weight_q.size()), FW'(0));
    check_output("frame_queue_level", FW'(frame_q.size()), FW'(m_hold));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
